// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two RAM requesters, the arbiter and the single-port RAM macro.
// The slave modport is the arbiter's view; the master modport is the requester/RAM side.
interface ram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] address_ram;
  logic [DATA_W-1:0] data_ram;
  logic              wren_ram;
  logic [DATA_W-1:0] q_ram;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output address_ram, data_ram, wren_ram,
    input  q_ram
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  address_ram, data_ram, wren_ram,
    output q_ram
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the single-port data RAM: core (port 0) has priority, the host (port 1)
// is bounded by a starvation counter, and a tag pipeline routes read data back to its issuer.
module ram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input logic          clock,
  input logic          reset,
  ram_arbiter_if.slave bus
);
  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  logic [3:0]        wait_cnt;
  logic              m1_wins;
  logic              gnt0;
  logic              gnt1;
  logic              rd_issue;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              we_sel;

  logic [RD_LAT:0]   tag_valid;
  logic [RD_LAT:0]   tag_id;

  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] data_q;
  logic              wren_q;
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  // Grants are gated by reset so nothing is accepted while the pipeline is being cleared.
  always_comb begin
    m1_wins   = bus.m1_req && ((wait_cnt >= WAIT_LIM) || !bus.m0_req);
    gnt1      = !reset && m1_wins;
    gnt0      = !reset && bus.m0_req && !m1_wins;
    addr_sel  = gnt1 ? bus.m1_addr  : bus.m0_addr;
    wdata_sel = gnt1 ? bus.m1_wdata : bus.m0_wdata;
    we_sel    = gnt1 ? bus.m1_we    : bus.m0_we;
    rd_issue  = (gnt0 || gnt1) && !we_sel;
  end

  assign bus.m0_gnt = gnt0;
  assign bus.m1_gnt = gnt1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (!bus.m1_req || gnt1) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != 4'hF) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Address and write data hold across idle cycles; only the write enable drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      address_q <= '0;
      data_q    <= '0;
      wren_q    <= 1'b0;
    end else if (gnt0 || gnt1) begin
      address_q <= addr_sel;
      data_q    <= wdata_sel;
      wren_q    <= we_sel;
    end else begin
      wren_q    <= 1'b0;
    end
  end

  // Stage RD_LAT lines up with q_ram for the read issued RD_LAT+1 edges earlier.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid <= {tag_valid[RD_LAT-1:0], rd_issue};
      tag_id    <= {tag_id[RD_LAT-1:0], gnt1};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= tag_valid[RD_LAT] && !tag_id[RD_LAT];
      rvalid1_q <= tag_valid[RD_LAT] &&  tag_id[RD_LAT];
      if (tag_valid[RD_LAT] && !tag_id[RD_LAT]) rdata0_q <= bus.q_ram;
      if (tag_valid[RD_LAT] &&  tag_id[RD_LAT]) rdata1_q <= bus.q_ram;
    end
  end

  assign bus.address_ram = address_q;
  assign bus.data_ram    = data_q;
  assign bus.wren_ram    = wren_q;
  assign bus.m0_rvalid   = rvalid0_q;
  assign bus.m1_rvalid   = rvalid1_q;
  assign bus.m0_rdata    = rdata0_q;
  assign bus.m1_rdata    = rdata1_q;
endmodule
